// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl: left-to-right square-and-multiply modexp sequencer driving one Montgomery multiplier.
// Build option LEADING_ZERO_SKIP_EN: squaring starts at the MSB set bit of exp instead of bit EXP_WIDTH-1.
module mont_modexp_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int EXP_WIDTH  = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exp,
  input  logic [WORD_WIDTH-1:0] r2,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  mm_enable,
  output logic [WORD_WIDTH-1:0] mm_x,
  output logic [WORD_WIDTH-1:0] mm_y,
  output logic [WORD_WIDTH-1:0] mm_m,
  input  logic                  mm_done,
  input  logic [WORD_WIDTH-1:0] mm_result
);
  localparam int BW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;
  typedef enum logic [2:0] {OP_BASE, OP_ONE, OP_SQ, OP_MUL, OP_OUT} op_t;
  state_t r_state, w_next;
  op_t r_op, w_op_next;
  logic [WORD_WIDTH-1:0] r_m, r_base, r_r2, r_acc, r_bbar, r_result;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [BW-1:0] r_bit, w_bit_next, w_bit_top;
  logic r_err, r_done, r_mm_enable, w_done, w_enable, w_accept, w_capture, w_skip_all;
  // The done cycle is already back in IDLE but still reports busy, so it must not accept.
  assign w_accept  = r_state == S_IDLE && start && !r_done;
  assign w_capture = r_state == S_WAIT && mm_done;
`ifdef LEADING_ZERO_SKIP_EN
  always_comb begin
    w_bit_top = '0;
    for (int i = 0; i < EXP_WIDTH; i++) if (r_exp[i]) w_bit_top = BW'(i);
  end
  assign w_skip_all = r_exp == '0;
`else
  assign w_bit_top  = BW'(EXP_WIDTH - 1);
  assign w_skip_all = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = m[0] ? S_ISSUE : S_FINISH;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mm_done) w_next = r_op == OP_OUT ? S_FINISH : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_op_next  = OP_OUT;
    w_bit_next = r_bit;
    case (r_op)
      OP_BASE: w_op_next = OP_ONE;
      OP_ONE: begin
        w_bit_next = w_bit_top;
        w_op_next  = w_skip_all ? OP_OUT : OP_SQ;
      end
      OP_SQ, OP_MUL: begin
        if (r_op == OP_SQ && r_exp[r_bit]) w_op_next = OP_MUL;
        else if (r_bit != '0) begin
          w_bit_next = r_bit - BW'(1);
          w_op_next  = OP_SQ;
        end
      end
      default: w_op_next = OP_OUT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m      <= '0;
      r_base   <= '0;
      r_r2     <= '0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_bbar   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_op     <= OP_BASE;
      r_bit    <= '0;
    end else if (w_accept) begin
      r_m    <= m;
      r_base <= base;
      r_exp  <= exp;
      r_r2   <= r2;
      r_op   <= OP_BASE;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_op  <= w_op_next;
      r_bit <= w_bit_next;
      if (r_op == OP_BASE) r_bbar <= mm_result;
      else if (r_op == OP_OUT) r_result <= mm_result;
      else r_acc <= mm_result;
    end else if (r_state == S_FINISH && !r_m[0]) begin
      r_err    <= 1'b1;
      r_result <= '0;
    end
  end
  always_comb begin
    w_enable = r_state == S_ISSUE;
    w_done   = r_state == S_FINISH;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mm_enable <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mm_enable <= w_enable;
      r_done      <= w_done;
    end
  end
  assign busy      = r_state != S_IDLE || r_done;
  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;
  assign mm_enable = r_mm_enable;
  assign mm_m      = r_m;
  assign mm_x      = r_op == OP_BASE ? r_base : r_op == OP_ONE ? WORD_WIDTH'(1) : r_acc;
  assign mm_y      = (r_op == OP_BASE || r_op == OP_ONE) ? r_r2 :
                     r_op == OP_SQ ? r_acc : r_op == OP_MUL ? r_bbar : WORD_WIDTH'(1);
endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// tb_mont_modexp_ctrl: directed runs against a plain-arithmetic modexp model and a random-latency multiplier.
module tb_mont_modexp_ctrl;
  localparam int W = 8;
`ifdef LEADING_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mm_done = 1'b0;
  logic [W-1:0] m = '0, base = '0, exp_i = '0, r2 = '0, mm_result = '0;
  logic busy, done, err, mm_enable;
  logic [W-1:0] result, mm_x, mm_y, mm_m;
  int checks = 0, passes = 0, cyc = 0, t_start = 0;
  int en_count = 0, lat_sum = 0, bfm_cnt = 0;
  bit bfm_pend = 1'b0, overlap = 1'b0, m_busy = 1'b0, e_err = 1'b0;
  logic [W-1:0] bfm_x = '0, bfm_y = '0, bfm_m = '0, e_m = '0;
  int e_s = 0, e_res = 0, e_ops = 0;

  mont_modexp_ctrl #(.WORD_WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .m(m), .base(base), .exp(exp_i), .r2(r2),
    .busy(busy), .done(done), .err(err), .result(result), .mm_enable(mm_enable),
    .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m), .mm_done(mm_done), .mm_result(mm_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int modexp(input int b, input int e, input int md);
    int r = 1 % md;
    for (int i = 0; i < e; i++) r = (r * b) % md;
    return r;
  endfunction

  function automatic int mont(input int x, input int y, input int md);
    for (int t = 0; t < md; t++) if ((t * 256) % md == (x * y) % md) return t;
    return -1;
  endfunction

  function automatic int ops_for(input logic [W-1:0] e);
    int msb = -1;
    for (int i = 0; i < W; i++) if (e[i]) msb = i;
    return 3 + (SKIP ? msb + 1 : W) + $countones(e);
  endfunction

  // Behavioural multiplier: random latency 1..20, answer computed by brute-force search.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      bfm_pend = 1'b0;
      mm_done  = 1'b0;
    end else begin
      mm_done = 1'b0;
      if (bfm_pend) begin
        bfm_cnt--;
        if (bfm_cnt == 0) begin
          mm_done   = 1'b1;
          mm_result = W'(mont(bfm_x, bfm_y, bfm_m));
          bfm_pend  = 1'b0;
        end
      end
      if (mm_enable) begin
        if (bfm_pend) overlap = 1'b1;
        bfm_pend = 1'b1;
        bfm_cnt  = $urandom_range(1, 20);
        bfm_x    = mm_x;
        bfm_y    = mm_y;
        bfm_m    = mm_m;
        en_count++;
        lat_sum += bfm_cnt + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) m_busy = 1'b0;
    else begin
      chk(busy == m_busy, "busy", busy, m_busy);
      if (bfm_pend || mm_done) begin
        chk(mm_x == bfm_x, "mm_x_stable", mm_x, bfm_x);
        chk(mm_y == bfm_y, "mm_y_stable", mm_y, bfm_y);
        chk(mm_m == e_m, "mm_m", mm_m, e_m);
      end
      if (mm_enable) chk(m_busy, "mm_enable_when_idle", m_busy, 1);
      if (done) begin
        chk(m_busy, "done_unexpected", m_busy, 1);
        chk(result == W'(e_res), "result", result, e_res);
        chk(err == e_err, "err", err, e_err);
        chk(en_count == e_ops, "op_count", en_count, e_ops);
        chk(cyc == e_s + 2 + lat_sum, "done_cycle", cyc, e_s + 2 + lat_sum);
        chk(!overlap, "serial_ops", overlap, 0);
        m_busy = 1'b0;
      end else if (start && !m_busy) begin
        e_s      = cyc;
        e_m      = m;
        e_err    = !m[0];
        e_res    = m[0] ? modexp(base, exp_i, m) : 0;
        e_ops    = m[0] ? ops_for(exp_i) : 0;
        en_count = 0;
        lat_sum  = 0;
        overlap  = 1'b0;
        m_busy   = 1'b1;
      end
    end
  end

  task automatic launch(input int mv, input int bv, input int ev, input int rv);
    @(posedge clk); #1;
    m = W'(mv); base = W'(bv); exp_i = W'(ev); r2 = W'(rv); start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int res, output int ens, output int lat, output int er);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk(1'b0, "done_timeout", 0, 1);
    res = result;
    ens = en_count;
    lat = cyc - t_start;
    er  = err;
  endtask

  initial begin
    int res, ens, lat, er;
    bit seen;
    repeat (2) @(negedge clk);
    chk(!busy, "rst_busy", busy, 0);
    chk(!done, "rst_done", done, 0);
    chk(!err, "rst_err", err, 0);
    chk(!mm_enable, "rst_mm_enable", mm_enable, 0);
    chk(result == 0, "rst_result", result, 0);
    chk(mm_x == 0 && mm_y == 0, "rst_mm_xy", {mm_x, mm_y}, 0);
    chk(mm_m == 0, "rst_mm_m", mm_m, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    launch(11, 4, 13, 9); wait_done(res, ens, lat, er);
    chk(res == 9, "lit_11_4_13", res, 9);
    chk(er == 0, "lit_11_err", er, 0);
    chk(ens == (SKIP ? 10 : 14), "lit_11_ops", ens, SKIP ? 10 : 14);
    launch(10, 3, 5, 0); wait_done(res, ens, lat, er);
    chk(res == 0, "lit_even_result", res, 0);
    chk(er == 1, "lit_even_err", er, 1);
    chk(ens == 0, "lit_even_ops", ens, 0);
    chk(lat == 2, "lit_even_latency", lat, 2);
    launch(13, 2, 7, 3); wait_done(res, ens, lat, er);
    chk(res == 11, "lit_13_2_7", res, 11);
    chk(er == 0, "lit_err_cleared", er, 0);
    launch(13, 5, 0, 3); wait_done(res, ens, lat, er);
    chk(res == 1, "lit_exp0", res, 1);
    chk(ens == (SKIP ? 3 : 11), "lit_exp0_ops", ens, SKIP ? 3 : 11);
    launch(1, 0, 5, 0); wait_done(res, ens, lat, er);
    chk(res == 0, "lit_m1", res, 0);
    launch(251, 200, 255, 25); wait_done(res, ens, lat, er);
    chk(res == 102, "lit_251_200_255", res, 102);
    chk(ens == 19, "lit_251_ops", ens, 19);
    launch(11, 4, 13, 9);
    repeat (30) @(posedge clk);
    #1;
    m = 13; base = 2; exp_i = 7; r2 = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(res, ens, lat, er);
    chk(res == 9, "lit_restart_ignored", res, 9);
    launch(11, 4, 13, 9);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bfm_pend;
    end
    chk(seen, "reached_wait", seen, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk(!busy, "abort_busy", busy, 0);
    chk(!done, "abort_done", done, 0);
    chk(!mm_enable, "abort_mm_enable", mm_enable, 0);
    chk(result == 0, "abort_result", result, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    launch(13, 2, 7, 3); wait_done(res, ens, lat, er);
    chk(res == 11, "lit_after_abort", res, 11);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
